// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Accepts one operand pair per input handshake and retires one quotient bit
// per cycle. Quotient and remainder are returned together through a
// valid/ready output port.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for an operand pair; the only state with io_in_ready high
//   CALC  | one shift/trial-subtract step per cycle, XLEN cycles in total
//   FIX   | apply result signs, register quotient and remainder
//   DONE  | result valid; held stable until the consumer accepts it
module seq_divider #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_in_valid,
  output logic            io_in_ready,
  input  logic [XLEN-1:0] io_a,
  input  logic [XLEN-1:0] io_b,
  input  logic            io_sign,
  input  logic            io_flush,
  output logic            io_out_valid,
  input  logic            io_out_ready,
  output logic [XLEN-1:0] io_quotient,
  output logic [XLEN-1:0] io_remainder,
  output logic            io_busy
);

  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_dvd;
  logic [XLEN-1:0]   r_dsr;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [XLEN-1:0]   r_quot;
  logic [XLEN-1:0]   r_remr;

  logic              w_accept;
  logic              w_b_zero;
  logic              w_ovf;
  logic              w_special;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN:0]     w_shift_rem;
  logic [XLEN:0]     w_trial;
  logic              w_trial_ok;

  // A flush in the same cycle as a valid input kills the accept.
  assign w_accept  = io_in_valid & io_in_ready & ~io_flush;

  // Special cases resolve in one cycle without iterating.
  assign w_b_zero  = (io_b == '0);
  assign w_ovf     = io_sign & (io_a == {1'b1, {(XLEN-1){1'b0}}}) & (io_b == '1);
  assign w_special = w_b_zero | w_ovf;

  // Magnitudes for signed mode; the most-negative dividend wraps to itself,
  // which is still the correct unsigned magnitude.
  assign w_a_neg   = io_sign & io_a[XLEN-1];
  assign w_b_neg   = io_sign & io_b[XLEN-1];
  assign w_a_mag   = w_a_neg ? -io_a : io_a;
  assign w_b_mag   = w_b_neg ? -io_b : io_b;

  // r_dvd shifts left each step: its MSB feeds the partial remainder and the
  // new quotient bit enters at the LSB, so after XLEN steps it holds the quotient.
  assign w_shift_rem = {r_rem, r_dvd[XLEN-1]};
  assign w_trial     = w_shift_rem - {1'b0, r_dsr};
  assign w_trial_ok  = ~w_trial[XLEN];

  assign io_quotient  = r_quot;
  assign io_remainder = r_remr;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs; flush overrides every transition.
  always_comb begin
    w_state_nxt  = r_state;
    io_in_ready  = 1'b0;
    io_out_valid = 1'b0;
    io_busy      = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        io_in_ready = 1'b1;
        io_busy     = 1'b0;
        if (w_accept) begin
          w_state_nxt = w_special ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_FIX;
        end
      end
      ST_FIX: begin
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        io_out_valid = 1'b1;
        if (io_out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (io_flush) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Datapath: operand capture, iteration, sign fix-up. Flush freezes it so the
  // result registers keep whatever they last held.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dsr   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_quot  <= '0;
      r_remr  <= '0;
    end else if (!io_flush) begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_cnt   <= CNT_W'(XLEN-1);
            r_rem   <= '0;
            r_dvd   <= w_a_mag;
            r_dsr   <= w_b_mag;
            if (w_b_zero) begin
              r_quot <= '1;
              r_remr <= io_a;
            end else if (w_ovf) begin
              r_quot <= io_a;
              r_remr <= '0;
            end
          end
        end
        ST_CALC: begin
          r_rem <= w_trial_ok ? w_trial[XLEN-1:0] : w_shift_rem[XLEN-1:0];
          r_dvd <= {r_dvd[XLEN-2:0], w_trial_ok};
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_FIX: begin
          r_quot <= r_neg_q ? -r_dvd : r_dvd;
          r_remr <= r_neg_r ? -r_rem : r_rem;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (XLEN = 64): directed vector table,
// randomized sweep against a plain-arithmetic reference, and hand-written
// sequences for backpressure, flush and mid-operation reset.
module tb_seq_divider;

  localparam int XLEN = 64;
  localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam int NORM_LAT = XLEN + 2;

  logic        clock;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [63:0] io_a;
  logic [63:0] io_b;
  logic        io_sign;
  logic        io_flush;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [63:0] io_quotient;
  logic [63:0] io_remainder;
  logic        io_busy;

  int n_pass  = 0;
  int n_total = 0;

  seq_divider #(.XLEN(XLEN)) dut (
    .clock       (clock),
    .reset       (reset),
    .io_in_valid (io_in_valid),
    .io_in_ready (io_in_ready),
    .io_a        (io_a),
    .io_b        (io_b),
    .io_sign     (io_sign),
    .io_flush    (io_flush),
    .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready),
    .io_quotient (io_quotient),
    .io_remainder(io_remainder),
    .io_busy     (io_busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sgn;
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h required 0x%016h", name, act, exp);
  endtask

  // Reference: RISC-V division semantics from plain arithmetic.
  function automatic void ref_div(input logic [63:0] a, input logic [63:0] b, input logic sgn,
                                  output logic [63:0] q, output logic [63:0] r);
    longint sa;
    longint sb;
    if (b == 64'd0) begin
      q = ONES;
      r = a;
    end else if (sgn && a == MIN_NEG && b == ONES) begin
      q = a;
      r = 64'd0;
    end else if (sgn) begin
      sa = a;
      sb = b;
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Accept one operand pair, scramble the operand inputs afterwards, and wait
  // (bounded) for out_valid. Returns at the negedge where out_valid is seen.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic sgn,
                       output logic [63:0] q, output logic [63:0] r, output int lat);
    int w = 0;
    while (!io_in_ready && w < 200) begin
      @(negedge clock);
      w++;
    end
    chk("in_ready_before_op", 64'(io_in_ready), 64'd1);
    io_a = a;
    io_b = b;
    io_sign = sgn;
    io_in_valid = 1'b1;
    @(negedge clock);
    io_in_valid = 1'b0;
    io_a = {$urandom, $urandom};
    io_b = {$urandom, $urandom};
    io_sign = 1'($urandom_range(0, 1));
    lat = 1;
    while (!io_out_valid && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    q = io_quotient;
    r = io_remainder;
  endtask

  // Full operation against the reference, including latency; retires the result.
  task automatic run_chk(input string name, input logic [63:0] a, input logic [63:0] b,
                         input logic sgn);
    logic [63:0] q, r, eq, er;
    int lat, elat;
    ref_div(a, b, sgn, eq, er);
    elat = (b == 64'd0 || (sgn && a == MIN_NEG && b == ONES)) ? 1 : NORM_LAT;
    do_op(a, b, sgn, q, r, lat);
    chk({name, "_q"}, q, eq);
    chk({name, "_r"}, r, er);
    chk({name, "_lat"}, 64'(lat), 64'(elat));
    @(negedge clock);
  endtask

  initial begin
    logic [63:0] q, r, q0, r0, a, b;
    logic sgn;
    int lat, hi_cnt;

    vecs[0]  = '{64'd100, 64'd7, 1'b0, 64'd14, 64'd2, NORM_LAT};
    vecs[1]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, ONES, NORM_LAT};
    vecs[2]  = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, NORM_LAT};
    vecs[3]  = '{64'd5, 64'd0, 1'b0, ONES, 64'd5, 1};
    vecs[4]  = '{64'd5, 64'd0, 1'b1, ONES, 64'd5, 1};
    vecs[5]  = '{MIN_NEG, ONES, 1'b1, MIN_NEG, 64'd0, 1};
    vecs[6]  = '{MIN_NEG, ONES, 1'b0, 64'd0, MIN_NEG, NORM_LAT};
    vecs[7]  = '{ONES, 64'd1, 1'b0, ONES, 64'd0, NORM_LAT};
    vecs[8]  = '{64'd0, 64'd5, 1'b1, 64'd0, 64'd0, NORM_LAT};
    vecs[9]  = '{64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 64'd14,
                 64'hFFFF_FFFF_FFFF_FFFE, NORM_LAT};
    vecs[10] = '{64'd1, ONES, 1'b0, 64'd0, 64'd1, NORM_LAT};
    vecs[11] = '{ONES, 64'd0, 1'b1, ONES, ONES, 1};

    reset = 1'b1;
    io_in_valid = 1'b0;
    io_a = '0;
    io_b = '0;
    io_sign = 1'b0;
    io_flush = 1'b0;
    io_out_ready = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_in_ready", 64'(io_in_ready), 64'd1);
    chk("rst_out_valid", 64'(io_out_valid), 64'd0);
    chk("rst_busy", 64'(io_busy), 64'd0);
    chk("rst_q", io_quotient, 64'd0);
    chk("rst_r", io_remainder, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sgn, q, r, lat);
      chk($sformatf("vec%0d_q", i), q, vecs[i].q);
      chk($sformatf("vec%0d_r", i), r, vecs[i].r);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      @(negedge clock);
    end

    for (int i = 0; i < 400; i++) begin
      sgn = 1'($urandom_range(0, 1));
      case (i % 4)
        0: begin
          a = 64'($urandom_range(0, 999999));
          b = 64'($urandom_range(1, 999999));
          if (sgn && $urandom_range(0, 1) == 1) a = -a;
          if (sgn && $urandom_range(0, 1) == 1) b = -b;
        end
        1: begin
          a = {$urandom, $urandom};
          b = {$urandom, $urandom};
        end
        2: begin
          a = {$urandom, $urandom};
          b = 64'($urandom_range(0, 15));
          if (sgn && $urandom_range(0, 1) == 1) b = -b;
        end
        default: begin
          a = ($urandom_range(0, 1) == 1) ? MIN_NEG : {$urandom, $urandom};
          b = ($urandom_range(0, 1) == 1) ? ONES : {32'd0, $urandom};
        end
      endcase
      run_chk($sformatf("rand%0d", i), a, b, sgn);
    end

    // Backpressure: result held while the consumer stalls.
    io_out_ready = 1'b0;
    do_op(64'd100, 64'd7, 1'b0, q0, r0, lat);
    chk("bp_q", q0, 64'd14);
    chk("bp_r", r0, 64'd2);
    io_in_valid = 1'b1;
    io_a = 64'd55;
    io_b = 64'd5;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      chk($sformatf("bp_hold%0d_vr", c), 64'({io_out_valid, io_in_ready}), 64'b10);
      chk($sformatf("bp_hold%0d_q", c), io_quotient, 64'd14);
      chk($sformatf("bp_hold%0d_r", c), io_remainder, 64'd2);
    end
    io_in_valid = 1'b0;
    io_out_ready = 1'b1;
    @(negedge clock);
    chk("bp_release_vr", 64'({io_out_valid, io_in_ready, io_busy}), 64'b010);

    // Flush at T+20 during CALC.
    io_a = 64'd200;
    io_b = 64'd3;
    io_sign = 1'b0;
    io_in_valid = 1'b1;
    @(negedge clock);
    io_in_valid = 1'b0;
    repeat (19) @(negedge clock);
    chk("fl_busy_before", 64'(io_busy), 64'd1);
    io_flush = 1'b1;
    @(negedge clock);
    io_flush = 1'b0;
    chk("fl_after_vrb", 64'({io_out_valid, io_in_ready, io_busy}), 64'b010);
    chk("fl_stale_q", io_quotient, 64'd14);
    chk("fl_stale_r", io_remainder, 64'd2);
    hi_cnt = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clock);
      if (io_out_valid) hi_cnt++;
    end
    chk("fl_out_valid_never", 64'(hi_cnt), 64'd0);
    run_chk("fl_next", 64'd200, 64'd3, 1'b0);

    // Flush in the same cycle as a valid input blocks the accept.
    io_a = 64'd9;
    io_b = 64'd2;
    io_in_valid = 1'b1;
    io_flush = 1'b1;
    @(negedge clock);
    io_in_valid = 1'b0;
    io_flush = 1'b0;
    chk("fl_block_accept", 64'({io_busy, io_in_ready}), 64'b01);
    repeat (3) @(negedge clock);
    chk("fl_block_no_result", 64'(io_out_valid), 64'd0);

    // Flush while DONE is waiting on the consumer.
    io_out_ready = 1'b0;
    do_op(64'd9, 64'd4, 1'b0, q, r, lat);
    chk("fl_done_q", q, 64'd2);
    io_flush = 1'b1;
    @(negedge clock);
    io_flush = 1'b0;
    io_out_ready = 1'b1;
    chk("fl_done_vr", 64'({io_out_valid, io_in_ready}), 64'b01);
    chk("fl_done_stale_r", io_remainder, 64'd1);

    // Reset mid-operation clears results too.
    io_a = 64'd1000;
    io_b = 64'd3;
    io_in_valid = 1'b1;
    @(negedge clock);
    io_in_valid = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst_mid_vrb", 64'({io_out_valid, io_in_ready, io_busy}), 64'b010);
    chk("rst_mid_q", io_quotient, 64'd0);
    chk("rst_mid_r", io_remainder, 64'd0);
    run_chk("rst_next", 64'd1000, 64'd3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
